// File: rtl/dbus_mem_responder_if.sv
// Data-bus interface between the core's memory stage (master) and a
// responder (slave).
//   dreq_*  : request from the master, held stable until dresp_data_ok
//   dresp_* : acknowledge (addr_ok), completion pulse (data_ok), read data, error
interface dbus_mem_responder_if;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        dresp_err;

  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data, dresp_err
  );

  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data, dresp_err
  );
endinterface

// File: rtl/dbus_mem_responder.sv
// Data-bus responder backed by an internal RAM of 64-bit words, with a
// configurable wait latency between accept and completion. Single outstanding
// transaction.
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high reset (RAM contents are kept)
//   dbus   - slave side of the data bus:
//            dreq_valid/addr/size/strobe/data in,
//            dresp_addr_ok (combinational accept), dresp_data_ok (one-cycle
//            completion pulse), dresp_data (full aligned word on reads, 0
//            otherwise), dresp_err (address outside RAM window)
module dbus_mem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  dbus_mem_responder_if.slave        dbus
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  logic [63:0] ram [MEM_WORDS];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [63:0]      hold_q,  hold_d;   // read word captured at accept
  logic             herr_q,  herr_d;   // range error captured at accept
  logic             data_ok_q, data_ok_d;
  logic [63:0]      data_q,  data_d;
  logic             err_q,   err_d;

  logic [63:0]      off_c;
  logic             in_range_c;
  logic [IDX_W-1:0] idx_c;
  logic             is_read_c;
  logic             accept_c;
  logic             wr_en_c;
  logic [63:0]      rd_word_c;
  logic             unused_c;

  // Address decode: byte offset from the window base, word index from bits [..:3]
  assign off_c      = dbus.dreq_addr - BASE_ADDR;
  assign in_range_c = (dbus.dreq_addr >= BASE_ADDR) && (off_c[63:IDX_W+3] == '0);
  assign idx_c      = off_c[IDX_W+2:3];
  assign is_read_c  = (dbus.dreq_strobe == 8'h00);

  // Size is informational only and the byte offset never selects a word
  assign unused_c = ^{dbus.dreq_size, off_c[2:0]};

  // Accept is only possible in IDLE and never while reset is asserted
  assign dbus.dresp_addr_ok = (state_q == S_IDLE) & dbus.dreq_valid & ~reset;
  assign accept_c           = dbus.dreq_valid & dbus.dresp_addr_ok;
  assign wr_en_c            = accept_c & in_range_c & ~is_read_c;

  // Writes and out-of-range reads both answer with an all-zero word
  assign rd_word_c = (in_range_c && is_read_c) ? ram[idx_c] : 64'h0;

  assign dbus.dresp_data_ok = data_ok_q;
  assign dbus.dresp_data    = data_q;
  assign dbus.dresp_err     = err_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    herr_d    = herr_q;
    data_ok_d = 1'b0;
    data_d    = 64'h0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          hold_d = rd_word_c;
          herr_d = ~in_range_c;
          if (LATENCY == 0) begin
            state_d   = S_RESP;
            data_ok_d = 1'b1;
            data_d    = rd_word_c;
            err_d     = ~in_range_c;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(LATENCY);
          end
        end
      end

      S_WAIT: begin
        // The response registers load on the last wait cycle so that
        // data_ok appears exactly in the RESP cycle.
        if (cnt_q <= CNT_W'(1)) begin
          state_d   = S_RESP;
          cnt_d     = '0;
          data_ok_d = 1'b1;
          data_d    = hold_q;
          err_d     = herr_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers plus RAM write port (RAM is not affected by reset)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hold_q    <= 64'h0;
      herr_q    <= 1'b0;
      data_ok_q <= 1'b0;
      data_q    <= 64'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      herr_q    <= herr_d;
      data_ok_q <= data_ok_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end

    if (wr_en_c) begin
      for (int i = 0; i < 8; i++) begin
        if (dbus.dreq_strobe[i]) begin
          ram[idx_c][8*i +: 8] <= dbus.dreq_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Self-checking bench for dbus_mem_responder: one instance with LATENCY=2
// (dut_a) and one with LATENCY=0 (dut_b), checked against a word-addressed
// associative-array memory model.
module tb_dbus_mem_responder;

  localparam int unsigned MEMW  = 1024;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          LAT_A = 2;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [63:0] mdl [longint unsigned];

  dbus_mem_responder_if if_a ();
  dbus_mem_responder_if if_b ();

  dbus_mem_responder #(.MEM_WORDS(MEMW), .BASE_ADDR(BASE), .LATENCY(LAT_A)) dut_a (
    .clk   (clk),
    .reset (reset),
    .dbus  (if_a)
  );

  dbus_mem_responder #(.MEM_WORDS(MEMW), .BASE_ADDR(BASE), .LATENCY(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .dbus  (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference memory: apply one request, return the expected response
  function automatic void model_apply(input logic [63:0] a, input logic [7:0] s,
                                      input logic [63:0] d,
                                      output logic [63:0] exp_d, output logic exp_e);
    longint unsigned idx;
    logic [63:0]     w;
    exp_d = 64'h0;
    exp_e = 1'b0;
    if (a < BASE || a >= BASE + 64'(MEMW) * 64'd8) begin
      exp_e = 1'b1;
      return;
    end
    idx = longint'((a - BASE) / 64'd8);
    w   = mdl.exists(idx) ? mdl[idx] : 64'h0;
    if (s == 8'h00) begin
      exp_d = w;
    end else begin
      for (int i = 0; i < 8; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      mdl[idx] = w;
    end
  endfunction

  // One full transaction on dut_a with timing checks; starts and ends just after a posedge
  task automatic txn_a(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                       output logic [63:0] rd, output logic er);
    bit seen;
    if_a.dreq_valid  = 1'b1;
    if_a.dreq_addr   = a;
    if_a.dreq_size   = 3'd3;
    if_a.dreq_strobe = s;
    if_a.dreq_data   = d;
    @(negedge clk);
    checks++;
    if (if_a.dresp_addr_ok !== 1'b1) begin
      failures++;
      $display("FAIL txn_accept addr=%h addr_ok=%b expected 1", a, if_a.dresp_addr_ok);
    end
    @(posedge clk); #1;
    seen = 1'b0;
    rd   = 64'h0;
    er   = 1'b0;
    for (int c = 1; c <= LAT_A + 4 && !seen; c++) begin
      @(negedge clk);
      checks++;
      if (if_a.dresp_addr_ok !== 1'b0) begin
        failures++;
        $display("FAIL txn_busy_addr_ok cycle=+%0d got %b expected 0", c, if_a.dresp_addr_ok);
      end
      if (if_a.dresp_data_ok === 1'b1) begin
        seen = 1'b1;
        rd   = if_a.dresp_data;
        er   = if_a.dresp_err;
        checks++;
        if (c != LAT_A + 1) begin
          failures++;
          $display("FAIL txn_latency data_ok at +%0d expected +%0d", c, LAT_A + 1);
        end
      end else begin
        checks++;
        if (if_a.dresp_data !== 64'h0 || if_a.dresp_err !== 1'b0) begin
          failures++;
          $display("FAIL txn_quiet_resp data=%h err=%b expected 0/0", if_a.dresp_data, if_a.dresp_err);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL txn_timeout addr=%h no data_ok within %0d cycles", a, LAT_A + 4);
    end
    @(posedge clk); #1;
    if_a.dreq_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if_a.dreq_valid = 1'b1; if_a.dreq_addr = BASE; if_a.dreq_size = 3'd3;
    if_a.dreq_strobe = 8'h00; if_a.dreq_data = 64'h0;
    if_b.dreq_valid = 1'b1; if_b.dreq_addr = BASE; if_b.dreq_size = 3'd3;
    if_b.dreq_strobe = 8'h00; if_b.dreq_data = 64'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (if_a.dresp_addr_ok !== 1'b0 || if_b.dresp_addr_ok !== 1'b0) begin
      failures++;
      $display("FAIL reset_addr_ok got %b/%b expected 0/0", if_a.dresp_addr_ok, if_b.dresp_addr_ok);
    end
    checks++;
    if ({if_a.dresp_data_ok, if_a.dresp_err, if_b.dresp_data_ok, if_b.dresp_err} !== 4'b0000 ||
        if_a.dresp_data !== 64'h0 || if_b.dresp_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_outputs data_ok=%b/%b err=%b/%b data=%h/%h expected all 0",
               if_a.dresp_data_ok, if_b.dresp_data_ok, if_a.dresp_err, if_b.dresp_err,
               if_a.dresp_data, if_b.dresp_data);
    end
    @(posedge clk); #1;
    if_a.dreq_valid = 1'b0;
    if_b.dreq_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (if_a.dresp_data_ok !== 1'b0 || if_a.dresp_addr_ok !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle data_ok=%b addr_ok=%b expected 0/0", if_a.dresp_data_ok, if_a.dresp_addr_ok);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_latency();
    logic [63:0] rd, ed;
    logic        er, ee;
    model_apply(BASE, 8'hFF, 64'h0123_4567_89AB_CDEF, ed, ee);
    txn_a(BASE, 8'hFF, 64'h0123_4567_89AB_CDEF, rd, er);
    model_apply(BASE, 8'h00, 64'h0, ed, ee);
    txn_a(BASE, 8'h00, 64'h0, rd, er);
    checks++;
    if (rd !== 64'h0123_4567_89AB_CDEF || er !== 1'b0) begin
      failures++;
      $display("FAIL read_word0 data=%h err=%b expected %h/0", rd, er, 64'h0123_4567_89AB_CDEF);
    end
  endtask

  task automatic test_byte_strobe();
    logic [63:0] rd, ed;
    logic        er, ee;
    model_apply(BASE + 64'h10, 8'hFF, 64'h1122_3344_5566_7788, ed, ee);
    txn_a(BASE + 64'h10, 8'hFF, 64'h1122_3344_5566_7788, rd, er);
    checks++;
    if (rd !== 64'h0 || er !== 1'b0) begin
      failures++;
      $display("FAIL write_resp data=%h err=%b expected 0/0", rd, er);
    end
    model_apply(BASE + 64'h10, 8'h02, 64'hAA00, ed, ee);
    txn_a(BASE + 64'h10, 8'h02, 64'hAA00, rd, er);
    txn_a(BASE + 64'h10, 8'h00, 64'h0, rd, er);
    checks++;
    if (rd !== 64'h1122_3344_5566_AA88 || er !== 1'b0) begin
      failures++;
      $display("FAIL strobe_merge data=%h err=%b expected 112233445566aa88/0", rd, er);
    end
  endtask

  task automatic test_out_of_range();
    logic [63:0] oor [2];
    logic [63:0] rd, ed;
    logic        er, ee;
    oor[0] = 64'h7FFF_FFF8;
    oor[1] = BASE + 64'(MEMW) * 64'd8;
    // Known contents in the first and last word (the indices those addresses would alias to)
    model_apply(BASE, 8'hFF, 64'h5A5A_0000_1111_2222, ed, ee);
    txn_a(BASE, 8'hFF, 64'h5A5A_0000_1111_2222, rd, er);
    model_apply(BASE + 64'(MEMW - 1) * 64'd8, 8'hFF, 64'hC3C3_3333_4444_5555, ed, ee);
    txn_a(BASE + 64'(MEMW - 1) * 64'd8, 8'hFF, 64'hC3C3_3333_4444_5555, rd, er);
    for (int k = 0; k < 2; k++) begin
      txn_a(oor[k], 8'h00, 64'h0, rd, er);
      checks++;
      if (rd !== 64'h0 || er !== 1'b1) begin
        failures++;
        $display("FAIL oor_read addr=%h data=%h err=%b expected 0/1", oor[k], rd, er);
      end
      txn_a(oor[k], 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, rd, er);
      checks++;
      if (rd !== 64'h0 || er !== 1'b1) begin
        failures++;
        $display("FAIL oor_write addr=%h data=%h err=%b expected 0/1", oor[k], rd, er);
      end
    end
    txn_a(BASE, 8'h00, 64'h0, rd, er);
    checks++;
    if (rd !== 64'h5A5A_0000_1111_2222 || er !== 1'b0) begin
      failures++;
      $display("FAIL oor_word0_kept data=%h err=%b expected 5a5a000011112222/0", rd, er);
    end
    txn_a(BASE + 64'(MEMW - 1) * 64'd8, 8'h00, 64'h0, rd, er);
    checks++;
    if (rd !== 64'hC3C3_3333_4444_5555 || er !== 1'b0) begin
      failures++;
      $display("FAIL oor_last_kept data=%h err=%b expected c3c3333344445555/0", rd, er);
    end
  endtask

  task automatic test_random();
    logic [63:0] a, d, rd, ed;
    logic [7:0]  s;
    logic        er, ee;
    logic [63:0] win;
    win = BASE + 64'h100;
    for (int w = 0; w < 16; w++) begin
      d = {$urandom, $urandom};
      model_apply(win + 64'(w) * 64'd8, 8'hFF, d, ed, ee);
      txn_a(win + 64'(w) * 64'd8, 8'hFF, d, rd, er);
    end
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 0) ? BASE - 64'($urandom_range(1, 64))
                                        : BASE + 64'(MEMW) * 64'd8 + 64'($urandom_range(0, 4095));
      else
        a = win + 64'($urandom_range(0, 127));
      s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      d = {$urandom, $urandom};
      model_apply(a, s, d, ed, ee);
      txn_a(a, s, d, rd, er);
      checks++;
      if (rd !== ed || er !== ee) begin
        failures++;
        $display("FAIL random_op n=%0d addr=%h strobe=%h data=%h err=%b expected %h/%b",
                 n, a, s, rd, er, ed, ee);
      end
    end
  endtask

  task automatic test_back_to_back_lat0();
    logic [63:0] word, d;
    logic [7:0]  s;
    word = 64'h0;
    if_b.dreq_valid = 1'b1;
    if_b.dreq_addr  = BASE + 64'h8;
    if_b.dreq_size  = 3'd3;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        d = {$urandom, $urandom};
        s = (k == 0) ? 8'hFF : 8'($urandom_range(1, 255));
        for (int i = 0; i < 8; i++) if (s[i]) word[8*i +: 8] = d[8*i +: 8];
      end else begin
        d = 64'h0;
        s = 8'h00;
      end
      if_b.dreq_strobe = s;
      if_b.dreq_data   = d;
      @(negedge clk);
      checks++;
      if (if_b.dresp_addr_ok !== 1'b1 || if_b.dresp_data_ok !== 1'b0) begin
        failures++;
        $display("FAIL lat0_accept k=%0d addr_ok=%b data_ok=%b expected 1/0", k, if_b.dresp_addr_ok, if_b.dresp_data_ok);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (if_b.dresp_addr_ok !== 1'b0 || if_b.dresp_data_ok !== 1'b1) begin
        failures++;
        $display("FAIL lat0_resp k=%0d addr_ok=%b data_ok=%b expected 0/1", k, if_b.dresp_addr_ok, if_b.dresp_data_ok);
      end
      checks++;
      if (if_b.dresp_data !== ((k % 2 == 0) ? 64'h0 : word) || if_b.dresp_err !== 1'b0) begin
        failures++;
        $display("FAIL lat0_data k=%0d data=%h err=%b expected %h/0", k, if_b.dresp_data,
                 if_b.dresp_err, (k % 2 == 0) ? 64'h0 : word);
      end
      @(posedge clk); #1;
    end
    if_b.dreq_valid = 1'b0;
  endtask

  task automatic test_drop_valid();
    logic [63:0] ed;
    logic        ee;
    model_apply(BASE + 64'h10, 8'h00, 64'h0, ed, ee);
    if_a.dreq_valid = 1'b1; if_a.dreq_addr = BASE + 64'h10;
    if_a.dreq_strobe = 8'h00; if_a.dreq_data = 64'h0;
    @(negedge clk);
    checks++;
    if (if_a.dresp_addr_ok !== 1'b1) begin
      failures++;
      $display("FAIL drop_accept addr_ok=%b expected 1", if_a.dresp_addr_ok);
    end
    @(posedge clk); #1;
    if_a.dreq_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++;
      if (if_a.dresp_data_ok !== ((c == LAT_A + 1) ? 1'b1 : 1'b0) || if_a.dresp_addr_ok !== 1'b0) begin
        failures++;
        $display("FAIL drop_timing cycle=+%0d data_ok=%b addr_ok=%b expected %b/0", c,
                 if_a.dresp_data_ok, if_a.dresp_addr_ok, (c == LAT_A + 1));
      end
      if (c == LAT_A + 1) begin
        checks++;
        if (if_a.dresp_data !== ed || if_a.dresp_err !== 1'b0) begin
          failures++;
          $display("FAIL drop_data data=%h err=%b expected %h/0", if_a.dresp_data, if_a.dresp_err, ed);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_txn();
    logic [63:0] ed, rd;
    logic        ee, er;
    bit          seen;
    // Read aborted by reset one cycle after accept, valid held throughout
    model_apply(BASE + 64'h10, 8'h00, 64'h0, ed, ee);
    if_a.dreq_valid = 1'b1; if_a.dreq_addr = BASE + 64'h10;
    if_a.dreq_strobe = 8'h00; if_a.dreq_data = 64'h0;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (if_a.dresp_data_ok !== 1'b0 || if_a.dresp_addr_ok !== 1'b0) begin
        failures++;
        $display("FAIL rst_abort cycle=+%0d data_ok=%b addr_ok=%b expected 0/0", c,
                 if_a.dresp_data_ok, if_a.dresp_addr_ok);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (if_a.dresp_addr_ok !== 1'b1) begin
      failures++;
      $display("FAIL rst_reaccept addr_ok=%b expected 1", if_a.dresp_addr_ok);
    end
    @(posedge clk); #1;
    seen = 1'b0;
    for (int c = 1; c <= LAT_A + 4 && !seen; c++) begin
      @(negedge clk);
      if (if_a.dresp_data_ok === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (c != LAT_A + 1 || if_a.dresp_data !== ed) begin
          failures++;
          $display("FAIL rst_new_txn at +%0d data=%h expected +%0d %h", c, if_a.dresp_data, LAT_A + 1, ed);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rst_new_txn_timeout no data_ok");
    end
    @(posedge clk); #1;
    if_a.dreq_valid = 1'b0;
    @(posedge clk); #1;
    // Write aborted by reset still lands in the RAM
    model_apply(BASE + 64'h18, 8'hFF, 64'hFEED_FACE_CAFE_F00D, ed, ee);
    if_a.dreq_valid = 1'b1; if_a.dreq_addr = BASE + 64'h18;
    if_a.dreq_strobe = 8'hFF; if_a.dreq_data = 64'hFEED_FACE_CAFE_F00D;
    @(posedge clk); #1;
    if_a.dreq_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    txn_a(BASE + 64'h18, 8'h00, 64'h0, rd, er);
    checks++;
    if (rd !== 64'hFEED_FACE_CAFE_F00D || er !== 1'b0) begin
      failures++;
      $display("FAIL rst_write_kept data=%h err=%b expected feedfacecafef00d/0", rd, er);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_read_latency();
    test_byte_strobe();
    test_out_of_range();
    test_random();
    test_back_to_back_lat0();
    test_drop_valid();
    test_reset_mid_txn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
